// File: rtl/onehot2bin_pipe.sv
// Registered one-hot to binary decoder with a 2-entry output FIFO, illegal-code flagging and a saturating error counter.
// One cycle from input transfer to out_valid when empty; in_ready comes only from registered occupancy, so out_ready never reaches it combinationally.
module onehot2bin_pipe #(
  parameter int W  = 4,
  parameter int N  = 2**W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bin,
  output logic          out_err,
  input  logic          err_clr,
  output logic [CW-1:0] err_cnt
);

  localparam logic [CW-1:0] ERR_MAX = '1;

  logic [W-1:0] dec_bin;
  logic         dec_err;
  logic         found;

  // Lowest set bit wins; any code that is not exactly one-hot is flagged.
  always_comb begin
    dec_bin = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_code[i] && !found) begin
        dec_bin = W'(i);
        found   = 1'b1;
      end
    end
    dec_err = !found || ((in_code & (in_code - N'(1))) != '0);
  end

  logic [W-1:0] bin_q [2];
  logic         err_q [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign out_bin   = bin_q[rd_ptr];
  assign out_err   = err_q[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bin_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        bin_q[wr_ptr] <= dec_bin;
        err_q[wr_ptr] <= dec_err;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Clear wins over increment, but an illegal code accepted on the clear edge still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (push && dec_err) ? CW'(1) : '0;
    end else if (push && dec_err && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_onehot2bin_pipe.sv
module tb_onehot2bin_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bin;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  onehot2bin_pipe #(.W(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] code;
    logic [3:0]  bin;
    logic        err;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the rules: exactly one bit set is legal, index of lowest set bit otherwise.
  function automatic logic [4:0] ref_decode(input logic [15:0] code);
    logic [3:0] b;
    b = 4'd0;
    for (int i = 15; i >= 0; i--) if (code[i]) b = 4'(i);
    return {b, ($countones(code) != 1)};
  endfunction

  initial begin
    logic [15:0] one;
    logic [4:0]  q[$];
    logic [4:0]  d;
    int          exp_cnt;
    int          pushed;
    int          cyc;
    bit          p, po;

    one = 16'h0001;
    for (int i = 0; i < 16; i++) vt[i] = '{one << i, 4'(i), 1'b0};
    vt[16] = '{16'h0000, 4'd0,  1'b1};
    vt[17] = '{16'h0048, 4'd3,  1'b1};
    vt[18] = '{16'hFFFF, 4'd0,  1'b1};
    vt[19] = '{16'h8001, 4'd0,  1'b1};
    vt[20] = '{16'hC000, 4'd14, 1'b1};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Table sweep: one per cycle, result visible one cycle later, no bubbles
    out_ready = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1;
      in_code  = vt[i].code;
      chk($sformatf("tab%0d_in_ready", i), in_ready, 1);
      step;
      if (vt[i].err) exp_cnt++;
      chk($sformatf("tab%0d_valid", i), out_valid, 1);
      chk($sformatf("tab%0d_bin", i), out_bin, vt[i].bin);
      chk($sformatf("tab%0d_err", i), out_err, vt[i].err);
      chk($sformatf("tab%0d_cnt", i), err_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    step;
    chk("tab_drain_valid", out_valid, 0);

    // Back-pressure: only two accepted, ordering preserved
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = one << 5;
    step;
    chk("bp_ready_after1", in_ready, 1);
    in_code = one << 6;
    step;
    chk("bp_ready_after2", in_ready, 0);
    in_code = one << 7;
    repeat (3) begin
      step;
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_bin", out_bin, 5);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step;
    chk("bp_ready_rise", in_ready, 1);
    chk("bp_out6", out_bin, 6);
    step;
    chk("bp_out7", out_bin, 7);
    chk("bp_out7_valid", out_valid, 1);
    in_valid = 1'b0;
    step;
    chk("bp_empty", out_valid, 0);

    // Randomized push/pop against a queue model
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    exp_cnt = 0;
    pushed  = 0;
    cyc     = 0;
    while (pushed < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (one << $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 99) < (((cyc / 64) % 2) ? 30 : 80));
      chk("rnd_in_ready", in_ready, (q.size() != 2));
      chk("rnd_out_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) chk("rnd_head", {out_bin, out_err}, q[0]);
      p  = in_valid && (q.size() < 2);
      po = out_ready && (q.size() > 0);
      d  = ref_decode(in_code);
      step;
      cyc++;
      if (po) void'(q.pop_front());
      if (p) begin
        q.push_back(d);
        pushed++;
        if (d[0] && exp_cnt < 255) exp_cnt++;
      end
      chk("rnd_err_cnt", err_cnt, exp_cnt);
    end
    chk("rnd_items_done", pushed, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0) begin
      chk("rnd_drain_head", {out_valid, out_bin, out_err}, {1'b1, q[0]});
      step;
      void'(q.pop_front());
    end
    chk("rnd_drain_empty", out_valid, 0);

    // Counter saturation and clear priority
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("sat_start", err_cnt, 0);
    in_valid = 1'b1;
    in_code  = 16'h0000;
    repeat (300) step;
    chk("sat_255", err_cnt, 255);
    step;
    chk("sat_stays", err_cnt, 255);
    err_clr = 1'b1;
    step;
    chk("clr_with_illegal", err_cnt, 1);
    in_valid = 1'b0;
    step;
    chk("clr_alone", err_cnt, 0);
    err_clr = 1'b0;
    step;
    chk("sat_drained", out_valid, 0);

    // Reset mid-operation with two entries buffered and err_cnt = 3
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 16'h0000;
    step;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    step;
    in_valid = 1'b0;
    chk("mid_pre_cnt", err_cnt, 3);
    chk("mid_pre_full", in_ready, 0);
    chk("mid_pre_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_bin", out_bin, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) begin
      step;
      chk("mid_no_stale", out_valid, 0);
    end
    in_valid = 1'b1;
    in_code  = one << 9;
    step;
    in_valid = 1'b0;
    chk("mid_fresh", {out_valid, out_bin, out_err}, {1'b1, 4'd9, 1'b0});
    chk("mid_fresh_cnt", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
